fb_pixel_unpacker: RTL and testbench
====================================

FB_PIXEL_UNPACKER -- requirements
Module: fb_pixel_unpacker

Interface
REQ-001 SHALL have parameter H_PIXELS, default 800, pixels per line (even, >=2).
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame (>=1).
REQ-003 SHALL have port clk_clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port fifo_read  out  1  read request to framebuffer FIFO output slave.
REQ-006 SHALL have port fifo_readdata  in  64  FIFO word; two 32-bit pixels, bits [31:0] first.
REQ-007 SHALL have port fifo_waitrequest  in  1  FIFO stall; word valid when fifo_read=1 and fifo_waitrequest=0.
REQ-008 SHALL have port frame_restart  in  1  single-cycle pulse; abort current frame and realign.
REQ-009 SHALL have port pix_data  out  32  current pixel.
REQ-010 SHALL have port pix_valid  out  1  pix_data valid.
REQ-011 SHALL have port pix_ready  in  1  downstream accepts pixel.
REQ-012 SHALL have port pix_sof  out  1  pixel is (x=0,y=0).
REQ-013 SHALL have port pix_eol  out  1  pixel is x=H_PIXELS-1.
REQ-014 SHALL have port underflow_count  out  16  only when FB_UNPACK_UNDERFLOW_CNT_EN defined.

Function
REQ-015 SHALL hold one 64-bit word register, valid flag and half index (0=low, 1=high).
REQ-016 SHALL define pixel transfer as pix_valid=1 and pix_ready=1 on a rising edge.
REQ-017 SHALL drive fifo_read=1 when holding register empty, or half=1 with transfer this cycle; never during frame_restart.
REQ-018 SHALL capture fifo_readdata on fifo_read=1 and fifo_waitrequest=0, set valid, half=0.
REQ-019 SHALL, on transfer with half=0, set half=1 without reading the FIFO.
REQ-020 SHALL, on transfer with half=1, clear valid unless a new word is captured the same edge (back-to-back, zero bubble).
REQ-021 SHALL drive pix_valid from the valid flag and pix_data from the selected half, both purely from registers.
REQ-022 SHALL hold pix_data, pix_sof, pix_eol stable while pix_valid=1 and pix_ready=0.
REQ-023 SHALL keep x counter 0..H_PIXELS-1 and y counter 0..V_LINES-1, advancing on transfer only.
REQ-024 SHALL wrap x to 0 and increment y after x=H_PIXELS-1; wrap y to 0 after y=V_LINES-1.
REQ-025 SHALL assert pix_sof=pix_valid&(x=0)&(y=0), pix_eol=pix_valid&(x=H_PIXELS-1).
REQ-026 SHALL, on frame_restart, clear valid, half, x and y on that edge; restart overrides a simultaneous transfer or capture, and the simultaneously presented FIFO word is not accepted (fifo_read=0).
REQ-027 SHALL keep pix_valid=0 while the FIFO stalls; no pixel duplicated or dropped across stalls.

Reset
REQ-028 SHALL, while reset_reset=1, force fifo_read=0, pix_valid=0, pix_sof=0, pix_eol=0, pix_data=0, counters=0, half=0, underflow_count=0.
REQ-029 SHALL resume reading on the first edge after reset_reset deasserts; reset mid-frame discards the held word.

Configuration
REQ-030 SHALL, with FB_UNPACK_UNDERFLOW_CNT_EN defined, increment underflow_count each cycle pix_ready=1 and pix_valid=0, saturating at 0xFFFF, cleared only by reset.
REQ-031 SHALL, without FB_UNPACK_UNDERFLOW_CNT_EN, omit port underflow_count and its logic; all other behaviour identical.

Verification (H_PIXELS=4, V_LINES=2)
REQ-032 SHALL test: FIFO words 0x00000002_00000001, 0x00000004_00000003, pix_ready=1 -> pixels 1,2,3,4 on consecutive cycles, sof with 1, eol with 4, fifo_read never idle with word held.
REQ-033 SHALL test: 8 pixels 1..8 -> eol on pixels 4 and 8, sof on 1; ninth pixel carries sof again.
REQ-034 SHALL test: pix_ready low 3 cycles after pixel 1 -> pix_data=2 held stable, then 2,3 resume with no loss.
REQ-035 SHALL test: fifo_waitrequest=1 for 5 cycles at word boundary -> pix_valid=0 for those cycles, underflow_count=5 (macro on).
REQ-036 SHALL test: frame_restart after pixel 3 accepted -> pixel 4 discarded, next FIFO word low half output with sof=1.
REQ-037 SHALL test: reset_reset pulsed mid-line -> all outputs 0 asynchronously, next word output with sof=1.

Source files
------------

// File: rtl/fb_pixel_unpacker.sv
// fb_pixel_unpacker: splits 64-bit framebuffer FIFO words into a 32-bit pixel stream with sof/eol framing.
// Defining FB_UNPACK_UNDERFLOW_CNT_EN adds the saturating underflow_count port.
module fb_pixel_unpacker #(
  parameter int H_PIXELS = 800,
  parameter int V_LINES  = 480
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  output logic        fifo_read,
  input  logic [63:0] fifo_readdata,
  input  logic        fifo_waitrequest,
  input  logic        frame_restart,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = V_LINES > 1 ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);
  logic [63:0]   word;
  logic          valid;
  logic          half;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          xfer;
  logic          capture;
  assign xfer      = valid & pix_ready;
  // Refill when empty, or on the edge that consumes the high half, so lines stream with no bubble.
  assign fifo_read = ~reset_reset & ~frame_restart & (~valid | (half & xfer));
  assign capture   = fifo_read & ~fifo_waitrequest;
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      word  <= '0;
      valid <= 1'b0;
      half  <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else if (frame_restart) begin
      valid <= 1'b0;
      half  <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else begin
      if (capture) begin
        word  <= fifo_readdata;
        valid <= 1'b1;
        half  <= 1'b0;
      end else if (xfer) begin
        {valid, half} <= half ? 2'b00 : 2'b11;
      end
      if (xfer) begin
        x <= (x == X_LAST) ? '0 : x + 1'b1;
        if (x == X_LAST) y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end
    end
  end
  assign pix_valid = valid;
  assign pix_data  = half ? word[63:32] : word[31:0];
  assign pix_sof   = valid & (x == '0) & (y == '0);
  assign pix_eol   = valid & (x == X_LAST);
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) underflow_count <= '0;
    else if (pix_ready & ~valid & ~&underflow_count) underflow_count <= underflow_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fb_pixel_unpacker.sv
// tb_fb_pixel_unpacker: directed and randomized checks of fb_pixel_unpacker against a pixel-queue model.
module tb_fb_pixel_unpacker;
  localparam int H = 4;
  localparam int V = 2;
  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        fifo_read;
  logic [63:0] fifo_readdata = '0;
  logic        fifo_waitrequest = 1'b1;
  logic        frame_restart = 1'b0;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_sof;
  logic        pix_eol;
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
  logic [15:0] u0;
`endif

  fb_pixel_unpacker #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .fifo_read(fifo_read),
    .fifo_readdata(fifo_readdata),
    .fifo_waitrequest(fifo_waitrequest),
    .frame_restart(frame_restart),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_sof(pix_sof),
    .pix_eol(pix_eol)
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic        sof;
    logic        eol;
    logic [31:0] d;
    int          cyc;
  } xfer_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          idx = 0;
  int          ucnt = 0;
  int          cyc = 0;
  logic        stall = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [63:0] words[$];
  logic [31:0] exp_pix[$];
  xfer_t       log_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive FIFO side, check outputs against the model, then advance the model across the edge.
  task automatic cycle();
    int   n;
    logic rd_exp;
    fifo_waitrequest = stall || words.size() == 0;
    fifo_readdata    = words.size() > 0 ? words[0] : {$urandom, $urandom};
    #1;
    n = exp_pix.size();
    if (reset_reset) begin
      chk("rst_fifo_read", 64'(fifo_read), 64'(0));
      chk("rst_pix_valid", 64'(pix_valid), 64'(0));
      chk("rst_pix_data", 64'(pix_data), 64'(0));
      chk("rst_pix_sof", 64'(pix_sof), 64'(0));
      chk("rst_pix_eol", 64'(pix_eol), 64'(0));
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
      chk("rst_underflow", 64'(underflow_count), 64'(0));
`endif
      exp_pix.delete();
      idx = 0;
      ucnt = 0;
      prev_hold = 1'b0;
    end else begin
      rd_exp = !frame_restart && (n == 0 || (n == 1 && pix_ready));
      chk("fifo_read", 64'(fifo_read), 64'(rd_exp));
      chk("pix_valid", 64'(pix_valid), 64'(n > 0));
      if (n > 0) begin
        chk("pix_data", 64'(pix_data), 64'(exp_pix[0]));
        chk("pix_sof", 64'(pix_sof), 64'(idx == 0));
        chk("pix_eol", 64'(pix_eol), 64'(idx % H == H - 1));
      end
      if (prev_hold) chk("hold_data", 64'(pix_data), 64'(prev_data));
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
      chk("underflow", 64'(underflow_count), 64'(ucnt));
`endif
      if (pix_ready && n == 0 && ucnt < 65535) ucnt++;
      prev_hold = n > 0 && !pix_ready && !frame_restart;
      prev_data = pix_data;
      if (frame_restart) begin
        exp_pix.delete();
        idx = 0;
      end else begin
        if (n > 0 && pix_ready) begin
          log_q.push_back('{pix_sof, pix_eol, pix_data, cyc});
          void'(exp_pix.pop_front());
          idx = (idx + 1) % (H * V);
        end
        if (rd_exp && !fifo_waitrequest) begin
          exp_pix.push_back(words[0][31:0]);
          exp_pix.push_back(words[0][63:32]);
          void'(words.pop_front());
        end
      end
    end
    cyc++;
    @(posedge clk_clk);
    @(negedge clk_clk);
  endtask

  task automatic run_until(input int target, input int budget);
    int k = 0;
    while (log_q.size() < target && k < budget) begin
      cycle();
      k++;
    end
    chk("pixel_timeout", 64'(log_q.size() >= target), 64'(1));
  endtask

  task automatic restart_pulse();
    frame_restart = 1'b1;
    cycle();
    frame_restart = 1'b0;
  endtask

  initial begin
    @(negedge clk_clk);
    cycle();
    cycle();
    reset_reset = 1'b0;
    // Two words streamed with ready held high: four back-to-back pixels.
    pix_ready = 1'b1;
    words.push_back(64'h00000002_00000001);
    words.push_back(64'h00000004_00000003);
    log_q.delete();
    repeat (6) cycle();
    chk("s1_count", 64'(log_q.size()), 64'(4));
    if (log_q.size() == 4) begin
      chk("s1_p1", 64'(log_q[0].d), 64'(1));
      chk("s1_p4", 64'(log_q[3].d), 64'(4));
      chk("s1_sof", 64'(log_q[0].sof), 64'(1));
      chk("s1_eol", 64'(log_q[3].eol), 64'(1));
      chk("s1_back_to_back", 64'(log_q[3].cyc - log_q[0].cyc), 64'(3));
    end
    // Second line completes the frame; the following pixel starts a new frame.
    words.push_back(64'h00000006_00000005);
    words.push_back(64'h00000008_00000007);
    words.push_back(64'h0000000a_00000009);
    log_q.delete();
    run_until(6, 30);
    if (log_q.size() >= 6) begin
      chk("s2_p5_sof", 64'(log_q[0].sof), 64'(0));
      chk("s2_p8", 64'({log_q[3].eol, log_q[3].d}), 64'({1'b1, 32'd8}));
      chk("s2_p9", 64'({log_q[4].sof, log_q[4].d}), 64'({1'b1, 32'd9}));
    end
    // Backpressure right after the first pixel.
    restart_pulse();
    words.push_back(64'h0000000c_0000000b);
    words.push_back(64'h0000000e_0000000d);
    log_q.delete();
    run_until(1, 20);
    pix_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("s3_hold", 64'(pix_data), 64'(32'h0c));
    end
    pix_ready = 1'b1;
    run_until(4, 20);
    if (log_q.size() >= 4) begin
      chk("s3_sof", 64'(log_q[0].sof), 64'(1));
      chk("s3_p2", 64'(log_q[1].d), 64'(32'h0c));
      chk("s3_p3", 64'(log_q[2].d), 64'(32'h0d));
    end
    // FIFO stall at a word boundary.
    stall = 1'b1;
    words.push_back(64'h00000010_0000000f);
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
    u0 = underflow_count;
`endif
    repeat (5) begin
      cycle();
      chk("s4_stall_valid", 64'(pix_valid), 64'(0));
    end
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
    chk("s4_underflow_delta", 64'(16'(underflow_count - u0)), 64'(5));
`endif
    stall = 1'b0;
    log_q.delete();
    run_until(2, 20);
    if (log_q.size() >= 2) chk("s4_resume", 64'({log_q[0].d, log_q[1].d}), {32'h0f, 32'h10});
    // Restart after the third pixel: the fourth is dropped.
    restart_pulse();
    words.push_back(64'h00000014_00000013);
    words.push_back(64'h00000016_00000015);
    words.push_back(64'h00000018_00000017);
    log_q.delete();
    run_until(3, 20);
    restart_pulse();
    run_until(4, 20);
    if (log_q.size() >= 4) chk("s5_after_restart", 64'({log_q[3].sof, log_q[3].d}), 64'({1'b1, 32'h17}));
    run_until(5, 20);
    // Asynchronous reset in the middle of a line.
    words.push_back(64'h0000001a_00000019);
    words.push_back(64'h0000001c_0000001b);
    log_q.delete();
    run_until(3, 20);
    #2 reset_reset = 1'b1;
    #1;
    chk("s6_async_valid", 64'(pix_valid), 64'(0));
    chk("s6_async_data", 64'(pix_data), 64'(0));
    chk("s6_async_read", 64'(fifo_read), 64'(0));
    chk("s6_async_flags", 64'({pix_sof, pix_eol}), 64'(0));
`ifdef FB_UNPACK_UNDERFLOW_CNT_EN
    chk("s6_async_underflow", 64'(underflow_count), 64'(0));
`endif
    @(negedge clk_clk);
    words.push_back(64'h0000001e_0000001d);
    cycle();
    cycle();
    reset_reset = 1'b0;
    log_q.delete();
    run_until(1, 20);
    if (log_q.size() >= 1) chk("s6_sof_after_reset", 64'(log_q[0].sof), 64'(1));
    // Randomized traffic with stalls, backpressure and occasional restarts.
    for (int i = 0; i < 800; i++) begin
      if (words.size() < 3) words.push_back({$urandom, $urandom});
      pix_ready     = $urandom_range(0, 3) != 0;
      stall         = $urandom_range(0, 4) == 0;
      frame_restart = $urandom_range(0, 60) == 0;
      cycle();
    end
    frame_restart = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
